// File: rtl/keypad_matrix_responder.sv
// Emulates a pressed key on a 3x3 matrix: bounce-in, hold, bounce-out, then a release gap.
// Latency: row follows column one cycle later. A request is accepted on the first cycle it meets IDLE.
// Backpressure: req_ready is low for the whole press; requests are not queued.
module keypad_matrix_responder #(
    parameter int HOLD_CYCLES   = 1000,
    parameter int BOUNCE_CYCLES = 64,
    parameter int BOUNCE_PERIOD = 8,
    parameter int GAP_CYCLES    = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] column,
    input  logic       req_valid,
    input  logic [3:0] req_key,
    output logic       req_ready,
    output logic [2:0] row,
    output logic       busy,
    output logic       done,
    output logic       bad_key
);

    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] BOUNCE_LAST = 16'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [15:0] GAP_LAST    = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [7:0]  PERIOD_LAST = 8'(BOUNCE_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        GAP
    } state_t;

    state_t      state;
    logic [3:0]  key;
    logic        contact;
    logic [15:0] phase_cnt;
    logic [7:0]  bounce_cnt;
    logic [2:0]  row_mask;
    logic [2:0]  col_mask;
    logic [2:0]  row_next;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Out-of-range keys decode to empty masks so they can never close a contact.
    always_comb begin
        row_mask = 3'b000;
        col_mask = 3'b000;
        case (key)
            4'd0: begin row_mask = 3'b001; col_mask = 3'b001; end
            4'd1: begin row_mask = 3'b001; col_mask = 3'b010; end
            4'd2: begin row_mask = 3'b001; col_mask = 3'b100; end
            4'd3: begin row_mask = 3'b010; col_mask = 3'b001; end
            4'd4: begin row_mask = 3'b010; col_mask = 3'b010; end
            4'd5: begin row_mask = 3'b010; col_mask = 3'b100; end
            4'd6: begin row_mask = 3'b100; col_mask = 3'b001; end
            4'd7: begin row_mask = 3'b100; col_mask = 3'b010; end
            4'd8: begin row_mask = 3'b100; col_mask = 3'b100; end
            default: begin row_mask = 3'b000; col_mask = 3'b000; end
        endcase
    end

    always_comb begin
        row_next = 3'b000;
        if (contact && (|(column & col_mask))) begin
            row_next = row_mask;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            key        <= 4'd0;
            contact    <= 1'b0;
            phase_cnt  <= 16'd0;
            bounce_cnt <= 8'd0;
            row        <= 3'b000;
            done       <= 1'b0;
            bad_key    <= 1'b0;
        end else begin
            done    <= 1'b0;
            bad_key <= 1'b0;
            row     <= row_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        key        <= req_key;
                        phase_cnt  <= 16'd0;
                        bounce_cnt <= 8'd0;
                        if (req_key > 4'd8) begin
                            state   <= GAP;
                            contact <= 1'b0;
                            bad_key <= 1'b1;
                        end else if (BOUNCE_CYCLES > 0) begin
                            state   <= BOUNCE_IN;
                            contact <= 1'b1;
                        end else begin
                            state   <= HOLD;
                            contact <= 1'b1;
                        end
                    end
                end
                BOUNCE_IN, BOUNCE_OUT: begin
                    // Leaving a bounce phase overrides any toggle due on the same edge.
                    if (phase_cnt == BOUNCE_LAST) begin
                        phase_cnt  <= 16'd0;
                        bounce_cnt <= 8'd0;
                        if (state == BOUNCE_IN) begin
                            state   <= HOLD;
                            contact <= 1'b1;
                        end else begin
                            state   <= GAP;
                            contact <= 1'b0;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                        if (bounce_cnt == PERIOD_LAST) begin
                            bounce_cnt <= 8'd0;
                            contact    <= ~contact;
                        end else begin
                            bounce_cnt <= bounce_cnt + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    if (phase_cnt == HOLD_LAST) begin
                        phase_cnt  <= 16'd0;
                        bounce_cnt <= 8'd0;
                        contact    <= 1'b0;
                        state      <= (BOUNCE_CYCLES > 0) ? BOUNCE_OUT : GAP;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (phase_cnt == GAP_LAST) begin
                        phase_cnt  <= 16'd0;
                        bounce_cnt <= 8'd0;
                        state      <= IDLE;
                        done       <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    contact <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Directed bench: responder "a" has no bounce (hold 10, gap 4), responder "b" bounces
// (16 cycles, period 4, hold 8, gap 2). All outputs are sampled 1 time unit after the rising edge.
module tb_keypad_matrix_responder;

    logic       clk = 1'b0;
    logic       reset;

    logic [2:0] col_a, col_b;
    logic       vld_a, vld_b;
    logic [3:0] key_a, key_b;
    logic       rdy_a, rdy_b;
    logic [2:0] row_a, row_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic       bad_a, bad_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    keypad_matrix_responder #(
        .HOLD_CYCLES(10), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(1), .GAP_CYCLES(4)
    ) dut_a (
        .clk(clk), .reset(reset), .column(col_a), .req_valid(vld_a), .req_key(key_a),
        .req_ready(rdy_a), .row(row_a), .busy(busy_a), .done(done_a), .bad_key(bad_a)
    );

    keypad_matrix_responder #(
        .HOLD_CYCLES(8), .BOUNCE_CYCLES(16), .BOUNCE_PERIOD(4), .GAP_CYCLES(2)
    ) dut_b (
        .clk(clk), .reset(reset), .column(col_b), .req_valid(vld_b), .req_key(key_b),
        .req_ready(rdy_b), .row(row_b), .busy(busy_b), .done(done_b), .bad_key(bad_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Contact level of responder b, m cycles after its accepting edge.
    function automatic logic contact_b(input int m);
        if (m >= 1 && m <= 16) return (((m - 1) / 4) % 2) == 0;
        if (m >= 17 && m <= 24) return 1'b1;
        if (m >= 25 && m <= 40) return (((m - 25) / 4) % 2) == 1;
        return 1'b0;
    endfunction

    initial begin
        logic [2:0] col_used;
        logic [2:0] exp_row;
        logic       exp_busy;
        int         pulses;

        reset = 1'b0;
        col_a = 3'b000; vld_a = 1'b0; key_a = 4'd0;
        col_b = 3'b000; vld_b = 1'b0; key_b = 4'd0;

        // Reset held: columns toggling must never raise a row.
        for (int i = 0; i < 4; i++) begin
            col_a = 3'(i + 1);
            col_b = 3'(i + 3);
            #7;
            check("rst_row_a", row_a, 0);
            check("rst_row_b", row_b, 0);
            check("rst_busy_a", busy_a, 0);
        end
        step();
        reset = 1'b1;
        step();
        check("rel_ready_a", rdy_a, 1);
        check("rel_ready_b", rdy_b, 1);
        check("rel_busy_a", busy_a, 0);
        check("rel_done_a", done_a, 0);
        check("rel_bad_a", bad_a, 0);

        // Key 4 press, request held through the press with a new key, multi-column cases.
        vld_a = 1'b1; key_a = 4'd4; col_a = 3'b010;
        for (int n = 1; n <= 17; n++) begin
            col_used = col_a;
            step();
            if (n == 17) exp_row = col_used[2] ? 3'b001 : 3'b000;
            else exp_row = (n >= 2 && n <= 11 && col_used[1]) ? 3'b010 : 3'b000;
            exp_busy = (n <= 14) || (n >= 16);
            check($sformatf("k4_row_n%0d", n), row_a, exp_row);
            check($sformatf("k4_busy_n%0d", n), busy_a, exp_busy);
            check($sformatf("k4_ready_n%0d", n), rdy_a, !exp_busy);
            check($sformatf("k4_done_n%0d", n), done_a, (n == 15));
            if (n == 1) key_a = 4'd2;
            if (n == 5) col_a = 3'b111;
            if (n == 7) col_a = 3'b101;
            if (n == 9) col_a = 3'b010;
            if (n == 15) col_a = 3'b100;
            if (n == 16) vld_a = 1'b0;
        end
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (done_a) pulses++;
        end
        check("k2_done_pulses", pulses, 1);
        check("k2_idle_busy", busy_a, 0);

        // Out-of-range key: bad_key pulse, no contact, done after the gap.
        vld_a = 1'b1; key_a = 4'd12; col_a = 3'b111;
        for (int n = 1; n <= 6; n++) begin
            step();
            check($sformatf("bad_pulse_n%0d", n), bad_a, (n == 1));
            check($sformatf("bad_done_n%0d", n), done_a, (n == 5));
            check($sformatf("bad_row_n%0d", n), row_a, 0);
            check($sformatf("bad_busy_n%0d", n), busy_a, (n <= 4));
            if (n == 1) vld_a = 1'b0;
        end

        // Rotating column scan with key 7 (row 2, column 1).
        vld_a = 1'b1; key_a = 4'd7; col_a = 3'b001;
        for (int n = 1; n <= 13; n++) begin
            col_used = col_a;
            step();
            exp_row = (n >= 2 && n <= 11 && col_used[1]) ? 3'b100 : 3'b000;
            check($sformatf("scan_row_n%0d", n), row_a, exp_row);
            if (n == 1) vld_a = 1'b0;
            col_a = 3'b001 << (n % 3);
        end
        for (int n = 0; n < 4; n++) step();
        check("scan_idle", busy_a, 0);

        // Bouncing press on key 0.
        vld_b = 1'b1; key_b = 4'd0; col_b = 3'b001;
        for (int n = 1; n <= 45; n++) begin
            step();
            check($sformatf("bnc_row_n%0d", n), row_b, contact_b(n - 1) ? 3'b001 : 3'b000);
            check($sformatf("bnc_done_n%0d", n), done_b, (n == 43));
            if (n == 1) vld_b = 1'b0;
        end

        // Reset in the middle of a hold on key 5.
        vld_a = 1'b1; key_a = 4'd5; col_a = 3'b100;
        step();
        vld_a = 1'b0;
        for (int n = 0; n < 3; n++) step();
        check("mid_row_before", row_a, 3'b010);
        reset = 1'b0;
        #1;
        check("mid_row_reset", row_a, 0);
        check("mid_busy_reset", busy_a, 0);
        #2;
        reset = 1'b1;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (done_a || busy_a) pulses++;
        end
        check("mid_no_done", pulses, 0);
        check("mid_row_after", row_a, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
